// File: rtl/pc_stack_unit.sv
// Program counter plus circular return stack for the fetch path.
// Selects the next fetch address from the execute-stage op and flags redirects for a one-slot flush.
module pc_stack_unit #(
   parameter int ADDR_WIDTH   = 13,
   parameter int LIT_WIDTH    = 11,
   parameter int PCLATH_WIDTH = 5,
   parameter int STACK_DEPTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR = 13'h004
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [2:0]                    op,
   input  logic [LIT_WIDTH-1:0]          k,
   input  logic [PCLATH_WIDTH-1:0]       pclath,
   input  logic [7:0]                    pcl_wdata,
   output logic [ADDR_WIDTH-1:0]         pc,
   output logic [7:0]                    pcl,
   output logic                          flush,
   output logic [$clog2(STACK_DEPTH)-1:0] sp,
   output logic                          stk_ovf,
   output logic                          stk_unf
);

   localparam int SP_W   = $clog2(STACK_DEPTH);
   localparam int CNT_W  = $clog2(STACK_DEPTH + 1);
   localparam int PAGE_W = ADDR_WIDTH - LIT_WIDTH;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_INC  = 3'd1,
      OP_GOTO = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4,
      OP_PCLW = 3'd5,
      OP_IRQ  = 3'd6,
      OP_SKIP = 3'd7
   } op_e;

   op_e                   op_dec;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
   logic [SP_W-1:0]       sp_dec;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   assign op_dec = op_e'(op);
   assign sp_dec = sp - SP_W'(1);
   assign pcl    = pc[7:0];

   // pc already points at the instruction after the one executing, so it is the return address
   always_comb begin
      next_pc = pc;
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      if (en) begin
         case (op_dec)
            OP_INC:  next_pc = pc + ADDR_WIDTH'(1);
            OP_SKIP: begin
               next_pc = pc + ADDR_WIDTH'(1);
               flush   = 1'b1;
            end
            OP_GOTO: begin
               next_pc = {pclath[PCLATH_WIDTH-1 -: PAGE_W], k};
               flush   = 1'b1;
            end
            OP_CALL: begin
               next_pc = {pclath[PCLATH_WIDTH-1 -: PAGE_W], k};
               push    = 1'b1;
               flush   = 1'b1;
            end
            OP_RET: begin
               next_pc = stack[sp_dec];
               pop     = 1'b1;
               flush   = 1'b1;
            end
            OP_PCLW: begin
               next_pc = ADDR_WIDTH'({pclath, pcl_wdata});
               flush   = 1'b1;
            end
            OP_IRQ: begin
               next_pc = IRQ_VECTOR;
               push    = 1'b1;
               flush   = 1'b1;
            end
            default: next_pc = pc;
         endcase
      end
   end

   // Occupancy saturates so overflow/underflow can be detected while sp keeps wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         sp      <= '0;
         count   <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else if (en) begin
         pc <= next_pc;
         if (push) begin
            sp <= sp + SP_W'(1);
            if (count == CNT_W'(STACK_DEPTH))
               stk_ovf <= 1'b1;
            else
               count <= count + CNT_W'(1);
         end else if (pop) begin
            sp <= sp_dec;
            if (count == '0)
               stk_unf <= 1'b1;
            else
               count <= count - CNT_W'(1);
         end
      end
   end

   // Stack storage has no reset; a full stack simply overwrites its oldest slot
   always_ff @(posedge clk) begin
      if (!rst && push)
         stack[sp] <= pc;
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios then randomized ops, all checked
// against an arithmetic model of the PC and return stack.
module tb_pc_stack_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  op;
   logic [10:0] k;
   logic [4:0]  pclath;
   logic [7:0]  pcl_wdata;
   logic [12:0] pc;
   logic [7:0]  pcl;
   logic        flush;
   logic [2:0]  sp;
   logic        stk_ovf;
   logic        stk_unf;

   int nCompared   = 0;
   int nMismatched = 0;

   // reference model state
   int mPc    = 0;
   int mSp    = 0;
   int mCount = 0;
   int mOvf   = 0;
   int mUnf   = 0;
   int mStack [8];

   pc_stack_unit dut (
      .clk(clk), .rst(rst), .en(en), .op(op), .k(k), .pclath(pclath),
      .pcl_wdata(pcl_wdata), .pc(pc), .pcl(pcl), .flush(flush), .sp(sp),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // model update for one rising edge, using the inputs held across it
   task automatic modelEdge();
      if (rst) begin
         mPc = 0; mSp = 0; mCount = 0; mOvf = 0; mUnf = 0;
      end else if (en) begin
         case (op)
            3'd1, 3'd7: mPc = (mPc + 1) % 8192;
            3'd2:       mPc = (int'(pclath) / 8) * 2048 + int'(k);
            3'd3, 3'd6: begin
               mStack[mSp] = mPc;
               mSp = (mSp + 1) % 8;
               if (mCount == 8) mOvf = 1; else mCount++;
               mPc = (op == 3'd3) ? (int'(pclath) / 8) * 2048 + int'(k) : 4;
            end
            3'd4: begin
               mSp = (mSp + 7) % 8;
               mPc = mStack[mSp];
               if (mCount == 0) mUnf = 1; else mCount--;
            end
            3'd5: mPc = int'(pclath) * 256 + int'(pcl_wdata);
            default: ;
         endcase
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic [2:0] o,
                                input logic [10:0] kk, input logic [4:0] pl, input logic [7:0] wd);
      @(negedge clk);
      rst = r; en = e; op = o; k = kk; pclath = pl; pcl_wdata = wd;
      #1;
      checkOutput("flush", {31'd0, flush}, (e && o >= 3'd2) ? 32'd1 : 32'd0);
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("pc", {19'd0, pc}, 32'(mPc));
      checkOutput("pcl", {24'd0, pcl}, 32'(mPc % 256));
      checkOutput("sp", {29'd0, sp}, 32'(mSp));
      checkOutput("stk_ovf", {31'd0, stk_ovf}, 32'(mOvf));
      checkOutput("stk_unf", {31'd0, stk_unf}, 32'(mUnf));
   endtask

   task automatic setPc(input logic [12:0] a);
      applyStimulus(1'b0, 1'b1, 3'd5, 11'd0, a[12:8], a[7:0]);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; op = 3'd0; k = '0; pclath = '0; pcl_wdata = '0;
      foreach (mStack[i]) mStack[i] = 0;

      // fill every stack slot once so later underflow reads are defined
      applyStimulus(1'b1, 1'b0, 3'd0, 11'd0, 5'd0, 8'd0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'd3, 11'(16 * i + 7), 5'd0, 8'd0);

      // scenario 1: reset then increments
      applyStimulus(1'b1, 1'b1, 3'd1, 11'd0, 5'd0, 8'd0);
      applyStimulus(1'b1, 1'b1, 3'd1, 11'd0, 5'd0, 8'd0);
      checkOutput("reset_pc", {19'd0, pc}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 1'b1, 3'd1, 11'd0, 5'd0, 8'd0);
         checkOutput("inc_pc", {19'd0, pc}, 32'(i));
      end

      // scenario 2: paged GOTO
      setPc(13'h010);
      applyStimulus(1'b0, 1'b1, 3'd2, 11'h123, 5'b11000, 8'd0);
      checkOutput("goto_pc", {19'd0, pc}, 32'h1923);

      // scenario 3: CALL, a few increments, RET
      setPc(13'h021);
      applyStimulus(1'b0, 1'b1, 3'd3, 11'h100, 5'd0, 8'd0);
      checkOutput("call_sp", {29'd0, sp}, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 3'd1, 11'd0, 5'd0, 8'd0);
      applyStimulus(1'b0, 1'b1, 3'd4, 11'd0, 5'd0, 8'd0);
      checkOutput("ret_pc", {19'd0, pc}, 32'h021);

      // scenario 4: overflow then underflow
      applyStimulus(1'b1, 1'b0, 3'd0, 11'd0, 5'd0, 8'd0);
      for (int i = 1; i <= 9; i++) begin
         setPc(13'(i));
         applyStimulus(1'b0, 1'b1, 3'd3, 11'h200, 5'd0, 8'd0);
      end
      checkOutput("ovf_flag", {31'd0, stk_ovf}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 1'b1, 3'd4, 11'd0, 5'd0, 8'd0);
         checkOutput("unf_ret_pc", {19'd0, pc}, (i == 0 || i == 8) ? 32'h009 : 32'(9 - i));
      end
      checkOutput("unf_flag", {31'd0, stk_unf}, 32'd1);

      // scenario 5: PCL write and wrap
      applyStimulus(1'b0, 1'b1, 3'd5, 11'd0, 5'h1F, 8'hAB);
      checkOutput("pclw_pc", {19'd0, pc}, 32'h1FAB);
      setPc(13'h1FFF);
      applyStimulus(1'b0, 1'b1, 3'd1, 11'd0, 5'd0, 8'd0);
      checkOutput("wrap_pc", {19'd0, pc}, 32'd0);

      // scenario 6: stall, interrupt, reset during CALL
      applyStimulus(1'b0, 1'b0, 3'd3, 11'h3FF, 5'h1F, 8'd0);
      setPc(13'h0555);
      applyStimulus(1'b0, 1'b1, 3'd6, 11'd0, 5'd0, 8'd0);
      checkOutput("irq_pc", {19'd0, pc}, 32'h004);
      applyStimulus(1'b0, 1'b1, 3'd4, 11'd0, 5'd0, 8'd0);
      checkOutput("irq_ret_pc", {19'd0, pc}, 32'h0555);
      applyStimulus(1'b0, 1'b1, 3'd3, 11'h111, 5'd0, 8'd0);
      applyStimulus(1'b1, 1'b1, 3'd3, 11'h222, 5'd0, 8'd0);
      checkOutput("rst_call_pc", {19'd0, pc}, 32'd0);

      // randomized ops with occasional stalls and resets
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                       3'($urandom_range(0, 7)), 11'($urandom), 5'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
